pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_next_pc.sv | 42 ++++
 rtl/pc_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared widths, reset/exception defaults and FSM encoding for the PC sequencer.
package pc_sequencer_pkg;

    localparam int ADDR_W = 32;
    localparam int TGT_W  = 26;
    localparam int OFF_W  = 16;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC   = 32'h0040_0000;
    localparam logic [ADDR_W-1:0] DEF_EXC_VECTOR = 32'h8000_0180;

    // ST_RST_IDLE is the extra idle cycle that follows reset release.
    typedef enum logic [1:0] {
        ST_RST_IDLE = 2'd0,
        ST_IDLE     = 2'd1,
        ST_REQ      = 2'd2,
        ST_VALID    = 2'd3
    } state_t;

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// Combinational next-PC selection: jr, then jump, then taken branch, then pc+4.
module next_pc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [ADDR_W-1:0] instr_pc_i,
    input  logic              jump_i,
    input  logic [TGT_W-1:0]  jump_target26_i,
    input  logic              branch_taken_i,
    input  logic [OFF_W-1:0]  branch_off16_i,
    input  logic              jr_i,
    input  logic [ADDR_W-1:0] jr_addr_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    function automatic logic signed [ADDR_W-1:0] branch_disp(input logic [OFF_W-1:0] off);
        return {{(ADDR_W-OFF_W-2){off[OFF_W-1]}}, off, 2'b00};
    endfunction

    logic [ADDR_W-1:0]        pc4;
    logic signed [ADDR_W-1:0] disp;
    logic [ADDR_W-1:0]        br_tgt;
    logic [ADDR_W-1:0]        j_tgt;
    logic [ADDR_W-1:0]        jr_tgt;

    assign pc4    = instr_pc_i + 32'd4;
    assign disp   = branch_disp(branch_off16_i);
    assign br_tgt = pc4 + $unsigned(disp);
    assign j_tgt  = {pc4[ADDR_W-1:ADDR_W-4], jump_target26_i, 2'b00};
    assign jr_tgt = jr_addr_i & ~32'h0000_0003;

    always_comb begin
        next_pc_o = pc4;
        if (jr_i) begin
            next_pc_o = jr_tgt;
        end else if (jump_i) begin
            next_pc_o = j_tgt;
        end else if (branch_taken_i) begin
            next_pc_o = br_tgt;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: single-outstanding fetch FSM, PC redirect and retire counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jump_target26,
    input  logic        branch_taken,
    input  logic [15:0] branch_off16,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        flush,
    output logic [31:0] retired_cnt
);

    state_t      state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic [31:0] retired_cnt_q;
    logic [31:0] retired_cnt_d;
    logic [31:0] next_pc;

    assign retired_cnt_d = retired_cnt_q + 32'd1;

    next_pc_calc u_next_pc (
        .instr_pc_i      (instr_pc_q),
        .jump_i          (jump),
        .jump_target26_i (jump_target26),
        .branch_taken_i  (branch_taken),
        .branch_off16_i  (branch_off16),
        .jr_i            (jr),
        .jr_addr_i       (jr_addr),
        .next_pc_o       (next_pc)
    );

    // Flush outranks both ack and consume, so it is decoded ahead of the state case.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RST_IDLE;
            pc_q          <= RESET_PC;
            req_q         <= 1'b0;
            valid_q       <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            retired_cnt_q <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            pc_q    <= EXC_VECTOR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                        req_q      <= 1'b0;
                        valid_q    <= 1'b1;
                        state_q    <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        pc_q          <= next_pc;
                        retired_cnt_q <= retired_cnt_d;
                        valid_q       <= 1'b0;
                        req_q         <= 1'b1;
                        state_q       <= ST_REQ;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign retired_cnt = retired_cnt_q;

endmodule
